// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flop; start/busy/done handshake, WIDTH+1 cycles per op.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic [CW-1:0]    cnt;
  logic             br, br_nxt, d, last, accept;

  // Full-subtractor cell on the current LSBs; result bits enter at the MSB side.
  always_comb begin
    d       = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    res_nxt = (res_sh >> 1) | (WIDTH'(d) << (WIDTH - 1));
    last    = (cnt == CW'(WIDTH - 1));
    accept  = start && ((state == IDLE) || (state == DONE));
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sh <= a;
        b_sh <= b;
        br   <= bin;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        br     <= br_nxt;
        res_sh <= res_nxt;
        cnt    <= cnt + 1'b1;
        // Outputs commit only on the MSB step; br here is the borrow into the MSB.
        if (last) begin
          diff <= res_nxt;
          bout <= br_nxt;
          ovf  <= br ^ br_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed vector table plus handshake/reset sequences on WIDTH=8, and random sweeps
// on WIDTH=1, 8 and 13 against an arithmetic reference.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, bin, busy, done, bout, ovf;
  logic [7:0]  a, b, diff;
  logic        s1_start, s1_a, s1_b, s1_bin, s1_busy, s1_done, s1_diff, s1_bout, s1_ovf;
  logic        s13_start, s13_bin, s13_busy, s13_done, s13_bout, s13_ovf;
  logic [12:0] s13_a, s13_b, s13_diff;

  int ncmp = 0;
  int nfail = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b), .bin(s1_bin),
    .busy(s1_busy), .done(s1_done), .diff(s1_diff), .bout(s1_bout), .ovf(s1_ovf)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(s13_start), .a(s13_a), .b(s13_b), .bin(s13_bin),
    .busy(s13_busy), .done(s13_done), .diff(s13_diff), .bout(s13_bout), .ovf(s13_ovf)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Returns {ovf, bout, diff[63:0]} for a w-bit subtraction, from exact integer arithmetic.
  function automatic logic [65:0] ref_sub(input int w, input logic [63:0] ra,
                                          input logic [63:0] rb, input logic rbin);
    logic [64:0] full;
    logic [63:0] mask;
    longint      sa, sb, ex, lo, hi;
    mask = (64'd1 << w) - 64'd1;
    full = {1'b0, ra} - {1'b0, rb} - {64'd0, rbin};
    sa = ra[w-1] ? longint'(ra) - (longint'(1) << w) : longint'(ra);
    sb = rb[w-1] ? longint'(rb) - (longint'(1) << w) : longint'(rb);
    ex = sa - sb - longint'(rbin);
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    return {(ex < lo) || (ex > hi), full[64], full[63:0] & mask};
  endfunction

  task automatic start_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    start = 1'b1;
    a     = ta;
    b     = tb;
    bin   = tbin;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle; diff must hold prev throughout RUN.
  task automatic wait_done8(input logic [7:0] prev, output int lat);
    logic ok;
    ok  = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (!busy || diff !== prev) ok = 1'b0;
    end
    chk("latency8", lat, 9);
    chk("busy_hold8", ok, 1);
    chk("busy_in_done8", busy, 0);
  endtask

  initial begin
    int          lat, nd, ld;
    logic [7:0]  prev;
    logic [65:0] r;
    logic [63:0] ra, rb;
    logic        rbin;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    s1_start = 1'b0; s1_a = 1'b0; s1_b = 1'b0; s1_bin = 1'b0;
    s13_start = 1'b0; s13_a = '0; s13_b = '0; s13_bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    prev = 8'h00;
    for (int i = 0; i < 7; i++) begin
      start_op8(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_done8(prev, lat);
      chk("vec_diff", diff, vecs[i].diff);
      chk("vec_bout", bout, vecs[i].bout);
      chk("vec_ovf", ovf, vecs[i].ovf);
      prev = vecs[i].diff;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end

    // Back-to-back: start raised in the DONE cycle
    start_op8(8'h33, 8'h11, 1'b0);
    wait_done8(prev, lat);
    chk("b2b_first", diff, 8'h22);
    start = 1'b1; a = 8'h01; b = 8'h02; bin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done8(8'h22, lat);
    chk("b2b_second", diff, 8'hFF);
    chk("b2b_bout", bout, 1);

    // Start held high with operands changing every cycle
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C; bin = 1'b0;
    nd = 0; ld = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1 a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      @(negedge clk);
      if (done) begin
        nd++;
        ld = i;
      end
    end
    start = 1'b0;
    chk("held_done_count", nd, 1);
    chk("held_done_at", ld, 9);
    chk("held_diff", diff, 8'h1E);
    chk("held_ovf", ovf, 0);
    @(posedge clk);
    #1;

    // Reset in RUN cycle 4 abandons the operation
    start_op8(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    chk("midrst_ovf", ovf, 0);
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("midrst_no_done", nd, 0);

    // rst and start together: rst wins
    rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; bin = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", busy, 0);
    start_op8(8'h5A, 8'h3C, 1'b0);
    wait_done8(8'h00, lat);
    chk("after_rst_diff", diff, 8'h1E);
    @(posedge clk);
    #1;

    // Random sweep, WIDTH=8
    prev = diff;
    for (int n = 0; n < 1000; n++) begin
      ra = 64'($urandom_range(255)); rb = 64'($urandom_range(255)); rbin = 1'($urandom);
      r = ref_sub(8, ra, rb, rbin);
      start_op8(ra[7:0], rb[7:0], rbin);
      wait_done8(prev, lat);
      chk("rnd8_diff", diff, r[7:0]);
      chk("rnd8_bout", bout, r[64]);
      chk("rnd8_ovf", ovf, r[65]);
      prev = r[7:0];
      @(posedge clk);
      #1;
    end

    // Random sweep, WIDTH=13
    for (int n = 0; n < 1000; n++) begin
      ra = 64'($urandom_range(8191)); rb = 64'($urandom_range(8191)); rbin = 1'($urandom);
      r = ref_sub(13, ra, rb, rbin);
      s13_a = ra[12:0]; s13_b = rb[12:0]; s13_bin = rbin; s13_start = 1'b1;
      @(posedge clk);
      #1 s13_start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (s13_done) begin
          lat = i;
          break;
        end
      end
      chk("latency13", lat, 14);
      chk("rnd13_diff", s13_diff, r[12:0]);
      chk("rnd13_bout", s13_bout, r[64]);
      chk("rnd13_ovf", s13_ovf, r[65]);
      @(posedge clk);
      #1;
    end

    // Random sweep, WIDTH=1
    for (int n = 0; n < 1000; n++) begin
      ra = 64'($urandom_range(1)); rb = 64'($urandom_range(1)); rbin = 1'($urandom);
      r = ref_sub(1, ra, rb, rbin);
      s1_a = ra[0]; s1_b = rb[0]; s1_bin = rbin; s1_start = 1'b1;
      @(posedge clk);
      #1 s1_start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (s1_done) begin
          lat = i;
          break;
        end
      end
      chk("latency1", lat, 2);
      chk("rnd1_diff", s1_diff, r[0]);
      chk("rnd1_bout", s1_bout, r[64]);
      chk("rnd1_ovf", s1_ovf, r[65]);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
